// File: rtl/mips_io_port.sv
// mips_io_port: memory-mapped I/O responder on the MIPS data bus.
// It provides a synchronized input port with change detection and a FIFO-drained output port.
module mips_io_port #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] port_out_data,
    output logic        port_out_valid,
    input  logic        port_out_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0]  sync1, sync2, prev;
    logic        inChanged, overflow;
    logic [31:0] lastOut, rdMux;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic [31:0] mem [FIFO_DEPTH];
    logic [1:0]  offset;
    logic        push, pop, doPush, ctrlWr, full, empty, chgSet, ovfSet, unusedBits;
    assign unusedBits = ^Address[1:0];
    assign offset = Address[3:2];
    assign Hit = Address[31:4] == BASE_ADDR[31:4];
    assign push = Hit & MemWrite & (offset == 2'd2);
    assign ctrlWr = Hit & MemWrite & (offset == 2'd3);
    assign empty = count == '0;
    // Depth is a power of two and count never exceeds it, so the MSB alone means full.
    assign full = count[AW];
    assign pop = port_out_valid & port_out_ready;
    assign doPush = push & (~full | pop);
    assign ovfSet = push & full & ~pop;
    assign chgSet = sync2 != prev;
    assign port_out_valid = ~empty;
    assign port_out_data = mem[rdPtr];
    always_comb begin
        rdMux = offset == 2'd0 ? {24'b0, sync2} :
                offset == 2'd1 ? {28'b0, overflow, full, empty, inChanged} :
                offset == 2'd2 ? lastOut : 32'h0;
    end
    assign ReadData = (Hit & MemRead) ? rdMux : 32'h0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev <= '0;
            inChanged <= 1'b0;
            overflow <= 1'b0;
            lastOut <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            prev <= sync2;
            // A set landing on the same edge as a clear takes priority.
            inChanged <= chgSet | (inChanged & ~(ctrlWr & WriteData[0]));
            overflow <= ovfSet | (overflow & ~(ctrlWr & WriteData[1]));
            if (push) lastOut <= WriteData;
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= WriteData;
    end
endmodule

// File: doc/mips_io_port.md
# mips_io_port

Memory-mapped I/O responder on the single-cycle MIPS data bus, i.e. the device end of the processor's load/store accesses. It decodes a 16-byte window and serves loads combinationally in the same cycle. It captures stores on the clock edge. It presents the external 8-bit input port through a synchronizer with change detection, and drains stored words through a 4-entry FIFO to an external consumer over a valid/ready handshake.

## Interface
Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base of the register window; bits [3:0] ignored.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from ALU result.
- WriteData  input  32  store data (rt value).
- MemWrite  input  1  store strobe, sampled at rising clk.
- MemRead  input  1  load strobe.
- ReadData  output  32  load data, combinational.
- Hit  output  1  combinational; Address[31:4] == BASE_ADDR[31:4].
- PortIn  input  8  asynchronous external input pins.
- port_out_data  output  32  FIFO head word.
- port_out_valid  output  1  FIFO non-empty.
- port_out_ready  input  1  consumer accepts head when high with valid.

## Operation
- Register map (offset = Address[3:2]):
  - 0 DATA_IN (R): {24'b0, in_sync}.
  - 1 STATUS (R): {28'b0, overflow, out_full, out_empty, in_changed}.
  - 2 DATA_OUT (R/W): write pushes WriteData; read returns last pushed word (last_out).
  - 3 CONTROL (W): bit0=1 clears in_changed; bit1=1 clears overflow; reads return 0.
- Address[1:0] ignored; only word accesses.
- ReadData = selected register when Hit & MemRead, else 32'h0.
- Writes need Hit & MemWrite; writes to offset 0/1 are ignored.
- Input path: PortIn → sync1 → sync2 (= in_sync) → prev. in_changed is set when sync2 != prev. It is sticky until cleared.
- Output FIFO: circular buffer with wr_ptr, rd_ptr and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Push: DATA_OUT write. Pop: port_out_valid & port_out_ready.
  - Push when full with no pop: data is dropped, overflow is set, last_out is still updated.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect. valid was 0, so no pop occurs.
- out_empty = (count==0). out_full = (count==FIFO_DEPTH). port_out_data = mem[rd_ptr]. Data is don't-care when empty; the bench checks only when valid.
- Set/clear collisions: when a set and a CONTROL clear land in the same cycle, set wins. This applies to both in_changed and overflow.

## Timing
- Reset (reset=0, async): sync1, sync2, prev, in_changed, overflow, last_out, pointers and count all go to 0. port_out_valid=0. ReadData=0 whenever no load hits. FIFO memory contents are not reset.
- Reset asserted mid-transfer empties the FIFO immediately. A valid word may be lost; the consumer must ignore valid during reset.
- Load latency: 0 cycles (combinational from Address/MemRead).
- Store latency: register updates at the rising edge where MemWrite is high. port_out_valid rises 1 cycle after the first push into an empty FIFO.
- Input latency: a PortIn change appears in DATA_IN 2 edges later. in_changed is set on edge 3.
- Handshake: valid stays high and data stays stable until a cycle with ready=1. Throughput is 1 word/cycle. Ready is not required to be low while valid=0.
- STATUS reflects register state before the current edge. A push and a STATUS read in the same cycle read the pre-push count.

## Test plan
- Reset then read all offsets at BASE_ADDR: DATA_IN=0, STATUS=32'h2 (empty), DATA_OUT=0, valid=0, Hit=0 at Address=0.
- PortIn 0x00→0xA5: DATA_IN=0x000000A5 after 2 edges, STATUS bit0=1 after 3. Write CONTROL=1: bit0 returns to 0. Repeat with a PortIn change colliding with the clear edge: bit0 stays 1.
- Push 0x11,0x22,0x33,0x44 with ready=0: STATUS=32'h4 (full). Push 0x55: STATUS=32'hC, DATA_OUT reads 0x55. Raise ready: 0x11..0x44 delivered in order, one per cycle, then valid=0.
- Full FIFO, push 0x66 with ready=1 in the same cycle: 0x11 popped, 0x66 accepted as 5th word delivered, overflow stays 0.
- Assert reset with 3 words queued and ready toggling: valid drops immediately. After release, STATUS=32'h2 and the next push 0x77 is the first word delivered.
- Store/load to BASE_ADDR+0x10 (miss): Hit=0, ReadData=0, no FIFO push, no status change.
